// File: rtl/rail_gate_pkg.sv
// Shared definitions for the railway gate monitor: FSM state encoding,
// system clock rate and a millisecond-to-cycles conversion helper.
package rail_gate_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OCCUPIED = 2'd1,
    HOLD     = 2'd2
  } gate_state_e;

  localparam int unsigned CLK_HZ = 100_000_000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return ms * (CLK_HZ / 1000);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One raw track sensor: 2-FF synchronizer, consecutive-cycle debouncer and
// a registered one-cycle strobe on each accepted rising edge.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic pulse_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q;

  // The counter only advances while the synced input disagrees, so it never
  // passes LAST: the level flips on the DEBOUNCE_CYCLES-th disagreeing cycle.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q       <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
      pulse_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], raw_i};
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
      pulse_q      <= level_q & ~level_prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/rail_sensor_conditioner.sv
// Railway gate front end: conditions approach/exit sensors, counts trains in
// the section, raises a sticky fault and drives train_present with a post-clear hold.
module rail_sensor_conditioner
  import rail_gate_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(10),
  parameter int unsigned HOLD_CYCLES     = ms_to_cycles(2000),
  parameter int unsigned CNT_W           = 3
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             approach_raw,
  input  logic             exit_raw,
  input  logic             fault_clr,
  output logic             train_present,
  output logic [CNT_W-1:0] occupancy,
  output logic             approach_pulse,
  output logic             exit_pulse,
  output logic             fault
);

  localparam int unsigned TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0]    HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] OCC_MAX   = '1;

  logic [CNT_W-1:0] occ_q, occ_d;
  logic             fault_q, fault_d;
  logic             fault_evt;
  logic [TW-1:0]    timer_q;
  gate_state_e      state_q;
  logic             train_present_q;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_approach (
    .clk_i  (clk_100MHz),
    .rst_ni (reset),
    .raw_i  (approach_raw),
    .pulse_o(approach_pulse)
  );

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_exit (
    .clk_i  (clk_100MHz),
    .rst_ni (reset),
    .raw_i  (exit_raw),
    .pulse_o(exit_pulse)
  );

  // Simultaneous approach and exit cancel out; a new fault event beats fault_clr.
  always_comb begin
    occ_d     = occ_q;
    fault_evt = 1'b0;
    case ({approach_pulse, exit_pulse})
      2'b10: begin
        if (occ_q == OCC_MAX) fault_evt = 1'b1;
        else                  occ_d     = occ_q + 1'b1;
      end
      2'b01: begin
        if (occ_q == '0) fault_evt = 1'b1;
        else             occ_d     = occ_q - 1'b1;
      end
      default: ;
    endcase
    fault_d = fault_evt | (fault_q & ~fault_clr);
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      occ_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      fault_q <= fault_d;
    end
  end

  // train_present is updated alongside the state so it always mirrors state != IDLE.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      train_present_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (occ_q != '0) begin
            state_q         <= OCCUPIED;
            train_present_q <= 1'b1;
          end
        end
        OCCUPIED: begin
          if (occ_q == '0) begin
            state_q <= HOLD;
            timer_q <= HOLD_LOAD;
          end
        end
        HOLD: begin
          if (occ_q != '0) begin
            state_q <= OCCUPIED;
            timer_q <= '0;
          end else if (timer_q == '0) begin
            state_q         <= IDLE;
            train_present_q <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          state_q         <= IDLE;
          timer_q         <= '0;
          train_present_q <= 1'b0;
        end
      endcase
    end
  end

  assign train_present = train_present_q;
  assign occupancy     = occ_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_rail_sensor_conditioner.sv
// Self-checking bench for rail_sensor_conditioner with short debounce/hold
// parameters; expected pulse cycles are queued when a sensor is raised.
module tb_rail_sensor_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       approach_raw = 1'b0;
  logic       exit_raw = 1'b0;
  logic       fault_clr = 1'b0;
  logic       train_present;
  logic [2:0] occupancy;
  logic       approach_pulse;
  logic       exit_pulse;
  logic       fault;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int ap_exp_q[$];
  int ex_exp_q[$];

  localparam int LAT = 2 + 4 + 1;

  rail_sensor_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .CNT_W          (3)
  ) dut (
    .clk_100MHz    (clk),
    .reset         (reset),
    .approach_raw  (approach_raw),
    .exit_raw      (exit_raw),
    .fault_clr     (fault_clr),
    .train_present (train_present),
    .occupancy     (occupancy),
    .approach_pulse(approach_pulse),
    .exit_pulse    (exit_pulse),
    .fault         (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic hw_reset();
    reset = 1'b0;
    approach_raw = 1'b0;
    exit_raw = 1'b0;
    fault_clr = 1'b0;
    ap_exp_q.delete();
    ex_exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Raises one sensor, queues the cycle its strobe is due, then waits for it.
  task automatic raise_and_catch(input bit is_exit, output int seen);
    int waited;
    int exp_c;
    @(negedge clk);
    if (is_exit) begin
      exit_raw = 1'b1;
      ex_exp_q.push_back(cyc + LAT);
    end else begin
      approach_raw = 1'b1;
      ap_exp_q.push_back(cyc + LAT);
    end
    waited = 0;
    seen = -1;
    while (waited < 30 && seen < 0) begin
      @(negedge clk);
      waited++;
      if ((is_exit ? exit_pulse : approach_pulse) === 1'b1) seen = cyc;
    end
    exp_c = is_exit ? ex_exp_q.pop_front() : ap_exp_q.pop_front();
    vectors++;
    if (seen != exp_c) begin
      miscompares++;
      $display("[TB] FAIL %s_latency: pulse at cycle %0d, required %0d",
               is_exit ? "exit" : "approach", seen, exp_c);
    end
  endtask

  task automatic release_sensor(input bit is_exit);
    int spurious;
    @(negedge clk);
    if (is_exit) exit_raw = 1'b0;
    else         approach_raw = 1'b0;
    spurious = 0;
    repeat (10) begin
      @(negedge clk);
      if ((is_exit ? exit_pulse : approach_pulse) !== 1'b0) spurious++;
    end
    vectors++;
    if (spurious != 0) begin
      miscompares++;
      $display("[TB] FAIL fall_no_pulse: %0d pulse cycles on release, required 0", spurious);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (train_present !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_train_present: got %b, required 0", train_present);
    end
    vectors++;
    if (occupancy !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_occupancy: got %0d, required 0", occupancy);
    end
    vectors++;
    if ({approach_pulse, exit_pulse, fault} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_pulses_fault: got %b, required 000",
               {approach_pulse, exit_pulse, fault});
    end
  endtask

  task automatic test_approach();
    int p;
    hw_reset();
    raise_and_catch(1'b0, p);
    @(negedge clk);
    vectors++;
    if (approach_pulse !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL pulse_width: approach_pulse %b one cycle later, required 0", approach_pulse);
    end
    vectors++;
    if (occupancy !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL approach_occupancy: got %0d, required 1", occupancy);
    end
    vectors++;
    if (train_present !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL train_present_early: got %b, required 0", train_present);
    end
    @(negedge clk);
    vectors++;
    if (train_present !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL train_present_rise: got %b, required 1", train_present);
    end
    release_sensor(1'b0);
  endtask

  task automatic test_bounce();
    int pulses;
    int tp_high;
    hw_reset();
    pulses = 0;
    tp_high = 0;
    for (int i = 0; i < 50; i++) begin
      if (i < 40 && (i % 2) == 0) approach_raw = ~approach_raw;
      @(negedge clk);
      if (approach_pulse !== 1'b0) pulses++;
      if (train_present !== 1'b0) tp_high++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("[TB] FAIL bounce_pulse: %0d pulses, required 0", pulses);
    end
    vectors++;
    if (occupancy !== 3'd0 || tp_high != 0) begin
      miscompares++;
      $display("[TB] FAIL bounce_state: occupancy %0d train_present cycles %0d, required 0 and 0",
               occupancy, tp_high);
    end
  endtask

  task automatic test_hold();
    int p;
    int seen;
    int low_cycles;
    int exp_c;
    hw_reset();
    raise_and_catch(1'b0, p);
    release_sensor(1'b0);
    raise_and_catch(1'b1, p);
    repeat (11) @(negedge clk);
    vectors++;
    if (train_present !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hold_before_fall: got %b at exit+11, required 1", train_present);
    end
    @(negedge clk);
    vectors++;
    if (train_present !== 1'b0 || occupancy !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL hold_fall: train_present %b occupancy %0d at exit+12, required 0 and 0",
               train_present, occupancy);
    end
    release_sensor(1'b1);

    // Re-approach while the hold timer is running.
    raise_and_catch(1'b0, p);
    release_sensor(1'b0);
    raise_and_catch(1'b1, p);
    approach_raw = 1'b1;
    ap_exp_q.push_back(p + LAT);
    seen = -1;
    low_cycles = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (train_present !== 1'b1) low_cycles++;
      if (approach_pulse === 1'b1 && seen < 0) seen = cyc;
    end
    exp_c = ap_exp_q.pop_front();
    vectors++;
    if (seen != exp_c) begin
      miscompares++;
      $display("[TB] FAIL hold_reapproach_latency: pulse at %0d, required %0d", seen, exp_c);
    end
    vectors++;
    if (low_cycles != 0 || occupancy !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL hold_reapproach: low cycles %0d occupancy %0d, required 0 and 1",
               low_cycles, occupancy);
    end
    release_sensor(1'b0);
    release_sensor(1'b1);
    raise_and_catch(1'b1, p);
    repeat (11) @(negedge clk);
    vectors++;
    if (train_present !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rehold_before_fall: got %b, required 1", train_present);
    end
    @(negedge clk);
    vectors++;
    if (train_present !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rehold_fall: got %b, required 0", train_present);
    end
    release_sensor(1'b1);
  endtask

  task automatic test_fault();
    int p;
    int occ_m;
    bit fault_m;
    hw_reset();
    raise_and_catch(1'b1, p);
    @(negedge clk);
    vectors++;
    if (fault !== 1'b1 || occupancy !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL underflow_fault: fault %b occupancy %0d, required 1 and 0", fault, occupancy);
    end
    release_sensor(1'b1);
    vectors++;
    if (fault !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL fault_sticky: got %b, required 1", fault);
    end
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    vectors++;
    if (fault !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fault_clear: got %b, required 0", fault);
    end
    occ_m = 0;
    fault_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raise_and_catch(1'b0, p);
      if (occ_m == 7) fault_m = 1'b1;
      else            occ_m++;
      @(negedge clk);
      vectors++;
      if (occupancy !== 3'(occ_m) || fault !== fault_m) begin
        miscompares++;
        $display("[TB] FAIL saturate_%0d: occupancy %0d fault %b, required %0d and %b",
                 i, occupancy, fault, occ_m, fault_m);
      end
      release_sensor(1'b0);
    end
  endtask

  task automatic test_back_to_back();
    int p;
    int waited;
    int seen;
    bit ex_seen;
    int exp_a;
    int exp_e;
    hw_reset();
    repeat (2) begin
      raise_and_catch(1'b0, p);
      release_sensor(1'b0);
    end
    @(negedge clk);
    approach_raw = 1'b1;
    exit_raw = 1'b1;
    ap_exp_q.push_back(cyc + LAT);
    ex_exp_q.push_back(cyc + LAT);
    waited = 0;
    seen = -1;
    ex_seen = 1'b0;
    while (waited < 30 && seen < 0) begin
      @(negedge clk);
      waited++;
      if (approach_pulse === 1'b1) begin
        seen = cyc;
        ex_seen = exit_pulse;
      end
    end
    exp_a = ap_exp_q.pop_front();
    exp_e = ex_exp_q.pop_front();
    vectors++;
    if (seen != exp_a || ex_seen !== 1'b1 || exp_e != exp_a) begin
      miscompares++;
      $display("[TB] FAIL both_pulses: approach at %0d exit_pulse %b, required %0d and 1",
               seen, ex_seen, exp_a);
    end
    @(negedge clk);
    vectors++;
    if (occupancy !== 3'd2 || fault !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL both_cancel: occupancy %0d fault %b, required 2 and 0", occupancy, fault);
    end
    release_sensor(1'b0);
    release_sensor(1'b1);
  endtask

  task automatic test_reset_mid();
    int p;
    int waited;
    int seen;
    bit ex_seen;
    int exp_a;
    hw_reset();
    raise_and_catch(1'b0, p);
    release_sensor(1'b0);
    raise_and_catch(1'b1, p);
    approach_raw = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (train_present !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_hold_present: got %b, required 1", train_present);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({train_present, occupancy, approach_pulse, exit_pulse, fault} !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: outputs %b, required all 0",
               {train_present, occupancy, approach_pulse, exit_pulse, fault});
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    ap_exp_q.push_back(cyc + LAT);
    waited = 0;
    seen = -1;
    ex_seen = 1'b0;
    while (waited < 30 && seen < 0) begin
      @(negedge clk);
      waited++;
      if (approach_pulse === 1'b1 || exit_pulse === 1'b1) begin
        seen = cyc;
        ex_seen = exit_pulse;
      end
    end
    exp_a = ap_exp_q.pop_front();
    vectors++;
    if (seen != exp_a || ex_seen !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL release_pulse: first pulse at %0d exit %b, required %0d and 1",
               seen, ex_seen, exp_a);
    end
    @(negedge clk);
    vectors++;
    if (occupancy !== 3'd0 || fault !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL release_state: occupancy %0d fault %b, required 0 and 0", occupancy, fault);
    end
  endtask

  initial begin
    test_reset();
    test_approach();
    test_bounce();
    test_hold();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
